// File: rtl/zbuf_pkg.sv
// Shared definitions for the depth-buffer unit: compare-function codes,
// clear-engine FSM encoding and the unsigned depth compare.
package zbuf_pkg;

  localparam logic [2:0] TF_NEVER    = 3'd0;
  localparam logic [2:0] TF_LESS     = 3'd1;
  localparam logic [2:0] TF_EQUAL    = 3'd2;
  localparam logic [2:0] TF_LEQUAL   = 3'd3;
  localparam logic [2:0] TF_GREATER  = 3'd4;
  localparam logic [2:0] TF_NOTEQUAL = 3'd5;
  localparam logic [2:0] TF_GEQUAL   = 3'd6;
  localparam logic [2:0] TF_ALWAYS   = 3'd7;

  typedef enum logic [1:0] {
    ZS_IDLE  = 2'd0,
    ZS_DRAIN = 2'd1,
    ZS_CLEAR = 2'd2,
    ZS_DONE  = 2'd3
  } zbuf_state_e;

  // Operands are zero-extended to 32 bits so one function serves any DEPTH_W <= 32.
  function automatic logic depth_cmp(input logic [2:0]  func,
                                     input logic [31:0] frag_z,
                                     input logic [31:0] stored_z);
    logic res;
    res = 1'b0;
    case (func)
      TF_NEVER:    res = 1'b0;
      TF_LESS:     res = (frag_z <  stored_z);
      TF_EQUAL:    res = (frag_z == stored_z);
      TF_LEQUAL:   res = (frag_z <= stored_z);
      TF_GREATER:  res = (frag_z >  stored_z);
      TF_NOTEQUAL: res = (frag_z != stored_z);
      TF_GEQUAL:   res = (frag_z >= stored_z);
      default:     res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/zbuf_depth_test_sdp_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module zbuf_sdp_ram #(
  parameter int SIZE    = 49152,
  parameter int DEPTH_W = 16,
  parameter int ADDR_W  = $clog2(SIZE)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [DEPTH_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [DEPTH_W-1:0] rdata
);

  logic [DEPTH_W-1:0] mem [SIZE];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/zbuf_depth_test.sv
// Pipelined depth test with write-back forwarding and a fast-clear engine.
// Optional ZBUF_STATS_EN adds saturating pass/fail counters.
module zbuf_depth_test
  import zbuf_pkg::*;
#(
  parameter int SIZE    = 49152,
  parameter int DEPTH_W = 16,
  parameter int ADDR_W  = $clog2(SIZE)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               frag_valid,
  output logic               frag_ready,
  input  logic [ADDR_W-1:0]  frag_addr,
  input  logic [DEPTH_W-1:0] frag_z,
  input  logic [2:0]         test_func,
  input  logic               z_write_en,
  output logic               out_valid,
  output logic               out_pass,
  output logic [ADDR_W-1:0]  out_addr,
  input  logic               clear_req,
  input  logic [DEPTH_W-1:0] clear_value,
  output logic               clear_busy,
  output logic               clear_done,
  output zbuf_state_e        dbg_state
`ifdef ZBUF_STATS_EN
  ,
  output logic [31:0]        stat_pass,
  output logic [31:0]        stat_fail
`endif
);

  // Handshake: a fragment transfers on a cycle where frag_valid & frag_ready
  // are both high; frag_valid need not wait for frag_ready. Results have no
  // backpressure: out_valid is a one-cycle strobe.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  zbuf_state_e state, state_nx;
  logic [DEPTH_W-1:0] clr_val;
  logic [ADDR_W-1:0]  clr_cnt;

  logic               accept;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [DEPTH_W-1:0] s1_z;
  logic [2:0]         s1_func;
  logic               s1_we;

  logic [DEPTH_W-1:0] ram_rdata;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [DEPTH_W-1:0] ram_wdata;

  logic               fwd_valid;
  logic [ADDR_W-1:0]  fwd_addr;
  logic [DEPTH_W-1:0] fwd_data;

  logic [DEPTH_W-1:0] stored_z;
  logic               pass;
  logic               wb_en;

  assign dbg_state = state;
  assign accept    = frag_valid & frag_ready;

  always_comb begin
    state_nx   = state;
    frag_ready = 1'b0;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      ZS_IDLE: begin
        frag_ready = ~rst;
        if (clear_req) state_nx = ZS_DRAIN;
      end
      ZS_DRAIN: begin
        clear_busy = 1'b1;
        // S0 is already empty because frag_ready is low here.
        if (!s1_valid) state_nx = ZS_CLEAR;
      end
      ZS_CLEAR: begin
        clear_busy = 1'b1;
        if (clr_cnt == LAST_ADDR) state_nx = ZS_DONE;
      end
      default: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
        state_nx   = ZS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= ZS_IDLE;
      clr_val <= '0;
      clr_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ZS_IDLE && clear_req) clr_val <= clear_value;
      if (state == ZS_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                   clr_cnt <= '0;
    end
  end

  // S0 -> S1 pipeline register; the RAM read is issued in the same cycle.
  always_ff @(posedge CLK) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_z     <= '0;
      s1_func  <= '0;
      s1_we    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= frag_addr;
        s1_z    <= frag_z;
        s1_func <= test_func;
        s1_we   <= z_write_en;
      end
    end
  end

  // The RAM returns pre-write data when the previous fragment's write-back
  // lands on the same edge as this fragment's read, so substitute it here.
  assign stored_z = (fwd_valid && fwd_addr == s1_addr) ? fwd_data : ram_rdata;
  assign pass     = depth_cmp(s1_func, 32'(s1_z), 32'(stored_z));
  assign wb_en    = s1_valid & pass & s1_we;

  always_comb begin
    ram_we    = wb_en;
    ram_waddr = s1_addr;
    ram_wdata = s1_z;
    if (state == ZS_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = clr_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= ram_we;
      fwd_addr  <= ram_waddr;
      fwd_data  <= ram_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pass  <= 1'b0;
      out_addr  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_pass  <= s1_valid & pass;
      out_addr  <= s1_valid ? s1_addr : out_addr;
    end
  end

  zbuf_sdp_ram #(
    .SIZE    (SIZE),
    .DEPTH_W (DEPTH_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (frag_addr),
    .rdata (ram_rdata)
  );

`ifdef ZBUF_STATS_EN
  logic clear_enter;
  assign clear_enter = (state == ZS_DRAIN) && (state_nx == ZS_CLEAR);

  always_ff @(posedge CLK) begin
    if (rst || clear_enter) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (s1_valid) begin
      if (pass && stat_pass != '1)  stat_pass <= stat_pass + 1'b1;
      if (!pass && stat_fail != '1) stat_fail <= stat_fail + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_zbuf_depth_test.sv
// Directed bench for zbuf_depth_test (SIZE=64): clear timing, compare truth
// table, forwarding, write-enable gating, clear/fragment overlap, reset mid-clear.
module tb_zbuf_depth_test;
  import zbuf_pkg::*;

  localparam int SIZE    = 64;
  localparam int DEPTH_W = 16;
  localparam int ADDR_W  = $clog2(SIZE);
  localparam int W       = ADDR_W + 1;

  logic               CLK = 1'b0;
  logic               rst;
  logic               frag_valid;
  logic               frag_ready;
  logic [ADDR_W-1:0]  frag_addr;
  logic [DEPTH_W-1:0] frag_z;
  logic [2:0]         test_func;
  logic               z_write_en;
  logic               out_valid;
  logic               out_pass;
  logic [ADDR_W-1:0]  out_addr;
  logic               clear_req;
  logic [DEPTH_W-1:0] clear_value;
  logic               clear_busy;
  logic               clear_done;
  zbuf_state_e        dbg_state;
`ifdef ZBUF_STATS_EN
  logic [31:0]        stat_pass;
  logic [31:0]        stat_fail;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  zbuf_depth_test #(.SIZE(SIZE), .DEPTH_W(DEPTH_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .rst(rst),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_addr(frag_addr), .frag_z(frag_z), .test_func(test_func),
    .z_write_en(z_write_en),
    .out_valid(out_valid), .out_pass(out_pass), .out_addr(out_addr),
    .clear_req(clear_req), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .dbg_state(dbg_state)
`ifdef ZBUF_STATS_EN
    , .stat_pass(stat_pass), .stat_fail(stat_fail)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: offer one fragment for one cycle and queue its expected result
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DEPTH_W-1:0] z,
                      input logic [2:0] f, input logic we, input logic exp_pass);
    frag_valid = 1'b1;
    frag_addr  = a;
    frag_z     = z;
    test_func  = f;
    z_write_en = we;
    exp_q.push_back({exp_pass, a});
    tick();
    frag_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      tick();
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // counts edges from the cycle after clear_req until clear_done is seen
  task automatic wait_done(input int exp_cycles);
    int cnt = 0;
    while (!clear_done && cnt < 200) begin
      tick();
      cnt++;
    end
    check("clear_lat", 32'(cnt), 32'(exp_cycles));
    check("done_ready", 32'(frag_ready), 32'd0);
    tick();
    check("done_pulse", 32'(clear_done), 32'd0);
    check("post_busy", 32'(clear_busy), 32'd0);
    check("post_ready", 32'(frag_ready), 32'd1);
  endtask

  // scoreboard
  always @(negedge CLK) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out_addr", 32'(out_addr), 32'(e[ADDR_W-1:0]));
        check("out_pass", 32'(out_pass), 32'(e[W-1]));
      end
    end
  end

  // stored = 100; columns frag_z = 99,100,101 (bit 2 is z=99)
  logic [2:0] truth [8];

  initial begin
    truth[0] = 3'b000; truth[1] = 3'b100; truth[2] = 3'b010; truth[3] = 3'b110;
    truth[4] = 3'b001; truth[5] = 3'b101; truth[6] = 3'b011; truth[7] = 3'b111;

    rst = 1'b1; frag_valid = 1'b0; frag_addr = '0; frag_z = '0; test_func = '0;
    z_write_en = 1'b0; clear_req = 1'b0; clear_value = '0;
    repeat (3) tick();
    check("rst_ready", 32'(frag_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pass", 32'(out_pass), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ZS_IDLE));
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(frag_ready), 32'd1);

    // fast clear to FFFF; done expected at t+2+SIZE, i.e. SIZE+1 edges after t+1
    clear_req = 1'b1; clear_value = 16'hFFFF;
    tick();
    clear_req = 1'b0;
    check("drain_busy", 32'(clear_busy), 32'd1);
    check("drain_ready", 32'(frag_ready), 32'd0);
    check("drain_state", 32'(dbg_state), 32'(ZS_DRAIN));
    wait_done(SIZE + 1);

    // LESS against FFFF, plus the equal boundary
    send(6'd0,  16'h0000, TF_LESS, 1'b0, 1'b1);
    send(6'd63, 16'hFFFE, TF_LESS, 1'b0, 1'b1);
    send(6'd31, 16'd1234, TF_LESS, 1'b0, 1'b1);
    send(6'd17, 16'hFFFF, TF_LESS, 1'b0, 1'b0);
    send(6'd40, 16'($urandom_range(0, 16'hFFFE)), TF_LESS, 1'b0, 1'b1);
    drain();

    // first-result latency: accepted at t, visible at t+2 only
    send(6'd3, 16'd7, TF_ALWAYS, 1'b0, 1'b1);
    check("lat_t1", 32'(out_valid), 32'd0);
    tick();
    check("lat_t2", 32'(out_valid), 32'd1);
    tick();
    check("lat_t3", 32'(out_valid), 32'd0);

    // address 5: 100 passes and is written, 200 then fails; entry holds 100
    send(6'd5, 16'd100, TF_LESS, 1'b1, 1'b1);
    tick(); tick();
    send(6'd5, 16'd200, TF_LESS, 1'b1, 1'b0);
    tick(); tick();
    send(6'd5, 16'd100, TF_EQUAL, 1'b0, 1'b1);
    drain();

    // address 9 back-to-back: second needs forwarding, third reads RAM
    send(6'd9, 16'd50, TF_LESS, 1'b1, 1'b1);
    send(6'd9, 16'd40, TF_LESS, 1'b1, 1'b1);
    send(6'd9, 16'd40, TF_EQUAL, 1'b0, 1'b1);
    send(6'd9, 16'd41, TF_LESS, 1'b0, 1'b0);
    drain();

    // truth-table sweep at stored = 100
    send(6'd20, 16'd100, TF_ALWAYS, 1'b1, 1'b1);
    for (int f = 0; f < 8; f++) begin
      send(6'd20, 16'd99,  3'(f), 1'b0, truth[f][2]);
      send(6'd20, 16'd100, 3'(f), 1'b0, truth[f][1]);
      send(6'd20, 16'd101, 3'(f), 1'b0, truth[f][0]);
    end
    drain();

    // passing fragment without write enable leaves memory untouched
    send(6'd20, 16'd150, TF_GREATER, 1'b0, 1'b1);
    send(6'd20, 16'd100, TF_EQUAL,   1'b0, 1'b1);
    drain();

    // clear requested alongside a fragment: fragment completes, DRAIN lasts
    // one extra cycle, and the clear then overwrites the fragment's write
    clear_req = 1'b1; clear_value = 16'h1234;
    send(6'd5, 16'd50, TF_LESS, 1'b1, 1'b1);
    clear_req = 1'b0;
    wait_done(SIZE + 2);
    check("overlap_result_seen", 32'(exp_q.size()), 32'd0);
    send(6'd5,  16'h1234, TF_EQUAL, 1'b0, 1'b1);
    send(6'd60, 16'h1234, TF_EQUAL, 1'b0, 1'b1);
    drain();

    // reset in the middle of a clear to zero
    clear_req = 1'b1; clear_value = 16'h0000;
    tick();
    clear_req = 1'b0;
    repeat (20) tick();
    check("mid_state", 32'(dbg_state), 32'(ZS_CLEAR));
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(clear_busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ZS_IDLE));
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < SIZE + 8; i++) begin
        if (clear_done) seen++;
        tick();
      end
      check("no_done_after_rst", 32'(seen), 32'd0);
    end
    send(6'd0,  16'h0000, TF_EQUAL, 1'b0, 1'b1);
    send(6'd60, 16'h1234, TF_EQUAL, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zbuf_depth_test.md
# zbuf_depth_test

Parametrised depth-buffer unit: owns a block-RAM depth store, performs a pipelined per-fragment depth test with a selectable compare function, and writes back passing depths. It provides a hardware fast-clear engine, and forwards read-after-write hazards so back-to-back fragments at the same address see the latest depth. It sits between the rasteriser fragment stream and the pixel write stage.

## Interface
- SIZE, 49152: number of depth entries.
- DEPTH_W, 16: depth word width.
- ADDR_W, $clog2(SIZE): address width.
- CLK  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- frag_valid  in  1  fragment offered.
- frag_ready  out  1  fragment accepted when frag_valid & frag_ready.
- frag_addr  in  ADDR_W  depth entry index.
- frag_z  in  DEPTH_W  incoming depth, unsigned.
- test_func  in  3  compare function, sampled with the fragment.
- z_write_en  in  1  write back on pass, sampled with the fragment.
- out_valid  out  1  result strobe, one cycle.
- out_pass  out  1  depth test result.
- out_addr  out  ADDR_W  address of the result.
- clear_req  in  1  start fast clear (level sampled in IDLE).
- clear_value  in  DEPTH_W  clear depth, sampled on clear start.
- clear_busy  out  1  high from clear start until done.
- clear_done  out  1  one-cycle pulse when clear completes.

## Operation
- test_func encoding: 0 NEVER, 1 LESS, 2 EQUAL, 3 LEQUAL, 4 GREATER, 5 NOTEQUAL, 6 GEQUAL, 7 ALWAYS; the relation is frag_z OP stored_z, unsigned, DEPTH_W bits.
- Write back only when pass & z_write_en; the written value is frag_z.
- Pipeline S0: accept the fragment and issue the RAM read. S1: RAM data valid; compare, write back, register the result.
- Forwarding: S1 keeps the last write (valid, addr, data). If the previous cycle's write address equals the current S1 address, the compare uses the forwarded data instead of the RAM output.
- The RAM is simple dual-port: one read port (S0), and one write port shared by S1 write-back and the clear engine.
- FSM states:
  - IDLE: frag_ready=1. On clear_req, go to DRAIN and latch clear_value. A fragment accepted in the same cycle as clear_req still completes.
  - DRAIN: frag_ready=0 until S0/S1 are empty, then go to CLEAR.
  - CLEAR: writes clear_value to address counter 0..SIZE-1, one per cycle. At SIZE-1, go to DONE.
  - DONE: clear_done=1 for one cycle, then go to IDLE.
- clear_busy=1 in DRAIN, CLEAR and DONE. clear_req outside IDLE is ignored.
- RAM contents are undefined after power-up until the first clear. rst does not clear memory.
- Reset mid-clear: FSM returns to IDLE, memory is partially cleared, no clear_done pulse, and in-flight fragments are dropped.

## Timing
- Reset values: out_valid 0, out_pass 0, out_addr 0, clear_busy 0, clear_done 0, FSM IDLE. frag_ready is 0 while rst is high.
- Fragment accepted at cycle t gives out_valid at t+2. Throughput is 1 fragment/cycle and there is no output backpressure.
- A write-back from the fragment at t is visible to the fragment accepted at t+1 via forwarding, and to the fragment at t+2 via the RAM.
- Clear from clear_req (IDLE, pipeline empty) at t: DRAIN at t+1, first clear write at t+2, clear_done at t+2+SIZE, frag_ready=1 at t+3+SIZE.

## Configuration
- ZBUF_STATS_EN defined adds outputs stat_pass and stat_fail, 32-bit saturating counters of tested fragments. They reset on rst and on entering CLEAR.
- ZBUF_STATS_EN undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- zbuf_pkg holds the test_func constants, the FSM state encoding, and the compare function.
- Sub-module zbuf_sdp_ram: simple dual-port block RAM with a registered read, DEPTH_W x SIZE.

## Test plan
- Clear with clear_value=16'hFFFF, SIZE=64 -> clear_done at t+2+64, then every LESS fragment with z<16'hFFFF passes.
- After clear, fragments at addr 5 with z=100, then z=200 (LESS, write) -> pass=1 then pass=0; entry 5 holds 100.
- Back-to-back at addr 9: z=50 then z=40 (LESS, write) on consecutive cycles -> both pass via forwarding; entry 9 holds 40.
- Sweep test_func 0..7 with stored=100 and frag_z in {99,100,101} -> matches the truth table; NEVER is always 0 and ALWAYS is always 1.
- z_write_en=0 with a passing fragment -> out_pass=1 and memory unchanged.
- clear_req in the same cycle as frag_valid -> the fragment result appears and is not clobbered before CLEAR. rst asserted mid-CLEAR -> clear_busy=0 next cycle and no clear_done pulse.
